par_bank_filter: RTL and testbench

Parametrised successor to the fixed 8-bank parallel pixel filter. Sweeps NUM_BANKS image banks in lockstep over a shared address and applies a 3-tap horizontal kernel independently per bank (lane). The kernel is either a weighted mean or a median, with edge replication at line boundaries. It emits one NUM_BANKS-pixel vector per cycle over a valid/ready stream, sitting between the banked pixel memories and the downstream writer.

---
 rtl/par_bank_filter_pkg.sv | 31 +++
 rtl/par_bank_filter_lane.sv | 63 ++++++
 rtl/par_bank_filter.sv | 218 +++++++++++++++++++++
 tb/tb_par_bank_filter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/par_bank_filter_pkg.sv
// Shared types and helpers for the banked 3-tap pixel filter.
// PBF_MEDIAN_EN in the lane/top enables the median kernel.
package par_filter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_MEAN   = 1'b0;
    localparam logic MODE_MEDIAN = 1'b1;

    localparam int MED_W = 32;

    function automatic logic [MED_W-1:0] med3(
        input logic [MED_W-1:0] a,
        input logic [MED_W-1:0] b,
        input logic [MED_W-1:0] c
    );
        logic [MED_W-1:0] lo;
        logic [MED_W-1:0] hi;
        logic [MED_W-1:0] m;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        m  = (hi < c) ? hi : c;
        return (lo > m) ? lo : m;
    endfunction

endpackage

// File: rtl/par_bank_filter_lane.sv
// One lane: 3-pixel sliding window with edge replication and kernel.
// Median kernel compiled only when PBF_MEDIAN_EN is defined.
module pbf_lane
    import par_filter_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             flush_i,
    input  logic             median_i,
    output logic [PIX_W-1:0] res_o
);

    logic [PIX_W-1:0] a_q;
    logic [PIX_W-1:0] a_d;
    logic [PIX_W-1:0] b_q;
    logic [PIX_W-1:0] b_d;
    logic [PIX_W-1:0] c;
    logic [PIX_W+1:0] sum;
    logic [PIX_W-1:0] mean;

    // First pixel of a line fills both taps so p[-1] replicates p[0].
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load_i) begin
            a_d = pix_i;
            b_d = pix_i;
        end else if (shift_i) begin
            a_d = b_q;
            b_d = pix_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign c    = flush_i ? b_q : pix_i;
    assign sum  = {2'b00, a_q} + {1'b0, b_q, 1'b0} + {2'b00, c};
    assign mean = sum[PIX_W+1:2];

`ifdef PBF_MEDIAN_EN
    logic [PIX_W-1:0] med;
    assign med   = PIX_W'(med3(MED_W'(a_q), MED_W'(b_q), MED_W'(c)));
    assign res_o = median_i ? med : mean;
`else
    logic unused_median;
    assign unused_median = median_i;
    assign res_o         = mean;
`endif

endmodule

// File: rtl/par_bank_filter.sv
// Banked lockstep 3-tap horizontal filter with valid/ready output.
// PBF_MEDIAN_EN adds the median kernel selected by mode.
module par_bank_filter
    import par_filter_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int PIX_W     = 8,
    parameter int LINE_W    = 86,
    parameter int NUM_LINES = 102,
    parameter int ADDR_W    = $clog2(LINE_W * NUM_LINES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [NUM_BANKS*PIX_W-1:0] mem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_BANKS*PIX_W-1:0] out_data,
    output logic                       busy,
    output logic                       done
);

    localparam int VW  = NUM_BANKS * PIX_W;
    localparam int XW  = $clog2(LINE_W);
    localparam int LNW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    localparam logic [XW-1:0]  X_LAST  = XW'(LINE_W - 1);
    localparam logic [LNW-1:0] LN_LAST = LNW'(NUM_LINES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [XW-1:0]     x_q;
    logic [XW-1:0]     x_d;
    logic [XW-1:0]     ax_q;
    logic [XW-1:0]     ax_d;
    logic [LNW-1:0]    ln_q;
    logic [LNW-1:0]    ln_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              mode_q;
    logic              mode_d;
    logic              rdv_q;
    logic              pend_q;
    logic              pend_d;
    logic [VW-1:0]     pdat_q;
    logic [VW-1:0]     pdat_d;
    logic              fl_q;
    logic              fl_d;
    logic              ov_q;
    logic              ov_d;
    logic              olast_q;
    logic              olast_d;
    logic [VW-1:0]     od_q;
    logic [VW-1:0]     od_d;

    logic          src_v;
    logic [VW-1:0] src;
    logic          out_free;
    logic          first;
    logic          acc;
    logic          emit;
    logic          rd;
    logic          hs_last;
    logic [VW-1:0] res;

    // Pixel source: the skid slot is older than data arriving this cycle.
    assign src_v    = pend_q | rdv_q;
    assign src      = pend_q ? pdat_q : mem_rdata;
    assign out_free = !ov_q | out_ready;
    assign first    = (ax_q == '0);
    assign acc      = src_v & (first | out_free);
    assign emit     = (acc & !first) | (fl_q & out_free);
    assign hs_last  = ov_q & out_ready & olast_q;

    genvar k;
    generate
        for (k = 0; k < NUM_BANKS; k++) begin : g_lane
            pbf_lane #(
                .PIX_W (PIX_W)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .pix_i    (src[k*PIX_W +: PIX_W]),
                .load_i   (acc & first),
                .shift_i  (acc & !first),
                .flush_i  (fl_q),
                .median_i (mode_q == MODE_MEDIAN),
                .res_o    (res[k*PIX_W +: PIX_W])
            );
        end
    endgenerate

    // Skid slot occupancy after this cycle; a read is only issued when
    // the slot will be empty, so a fully stalled next cycle still fits.
    always_comb begin
        pend_d = pend_q;
        pdat_d = pdat_q;
        if (pend_q) begin
            pend_d = !acc | rdv_q;
        end else begin
            pend_d = rdv_q & !acc;
        end
        if (rdv_q && (pend_q == acc)) begin
            pdat_d = mem_rdata;
        end
    end

    assign rd = (state_q == READ) & !pend_d;

    always_comb begin
        ax_d    = ax_q;
        fl_d    = fl_q & !out_free;
        ov_d    = ov_q;
        olast_d = olast_q;
        od_d    = od_q;
        if (acc) begin
            ax_d = (ax_q == X_LAST) ? '0 : ax_q + 1'b1;
            if (ax_q == X_LAST) begin
                fl_d = 1'b1;
            end
        end
        if (emit) begin
            ov_d    = 1'b1;
            od_d    = res;
            olast_d = fl_q;
        end else if (out_ready) begin
            ov_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        ln_d    = ln_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    x_d     = '0;
                    ln_d    = '0;
                    addr_d  = '0;
                    mode_d  = mode;
                end
            end
            READ: begin
                if (rd) begin
                    addr_d = addr_q + 1'b1;
                    x_d    = x_q + 1'b1;
                    if (x_q == X_LAST) begin
                        x_d     = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (hs_last) begin
                    if (ln_q == LN_LAST) begin
                        state_d = DONE;
                    end else begin
                        ln_d    = ln_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            ax_q    <= '0;
            ln_q    <= '0;
            addr_q  <= '0;
            mode_q  <= MODE_MEAN;
            rdv_q   <= 1'b0;
            pend_q  <= 1'b0;
            pdat_q  <= '0;
            fl_q    <= 1'b0;
            ov_q    <= 1'b0;
            olast_q <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            ax_q    <= ax_d;
            ln_q    <= ln_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            rdv_q   <= rd;
            pend_q  <= pend_d;
            pdat_q  <= pdat_d;
            fl_q    <= fl_d;
            ov_q    <= ov_d;
            olast_q <= olast_d;
            od_q    <= od_d;
        end
    end

    assign mem_rd_en = rd;
    assign mem_addr  = addr_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign busy      = (state_q == READ) | (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_par_bank_filter.sv
// Directed and randomized frames checked against a pixel-array model.
// Expected kernel follows PBF_MEDIAN_EN the same way the design does.
module tb_par_bank_filter;

    localparam int NB    = 2;
    localparam int PW    = 8;
    localparam int LW    = 4;
    localparam int NL    = 2;
    localparam int DEPTH = LW * NL;
    localparam int AW    = $clog2(DEPTH);
    localparam int VW    = NB * PW;
`ifdef PBF_MEDIAN_EN
    localparam bit MED_EN = 1'b1;
`else
    localparam bit MED_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [VW-1:0] mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] mem [NB][DEPTH];
    logic [VW-1:0] cap [DEPTH];

    always #5 clk = ~clk;

    par_bank_filter #(
        .NUM_BANKS (NB),
        .PIX_W     (PW),
        .LINE_W    (LW),
        .NUM_LINES (NL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always @(posedge clk) begin
        if (mem_rd_en) begin
            for (int k = 0; k < NB; k++) begin
                mem_rdata[k*PW +: PW] <= mem[k][mem_addr];
            end
        end
    end

    function automatic int pix(int k, int line, int i);
        int j;
        j = (i < 0) ? 0 : ((i >= LW) ? LW - 1 : i);
        return int'(mem[k][line*LW + j]);
    endfunction

    function automatic logic [VW-1:0] ref_vec(int line, int x, bit md);
        logic [VW-1:0] v;
        int a, b, c, mx, mn, r;
        v = '0;
        for (int k = 0; k < NB; k++) begin
            a = pix(k, line, x - 1);
            b = pix(k, line, x);
            c = pix(k, line, x + 1);
            if (md && MED_EN) begin
                mx = (a > b) ? a : b;
                mx = (mx > c) ? mx : c;
                mn = (a < b) ? a : b;
                mn = (mn < c) ? mn : c;
                r  = a + b + c - mx - mn;
            end else begin
                r = (a + 2 * b + c) / 4;
            end
            v[k*PW +: PW] = PW'(r);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < NB; k++)
            for (int a = 0; a < DEPTH; a++)
                mem[k][a] = PW'($urandom);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_rd"}, mem_rd_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // rmode: 0 ready high, 1 fixed 1,0,0,1,0,1 pattern, 2 random
    task automatic run_frame(input bit md, input int rmode,
                             input bit timing, input int again);
        int cyc, hs, rds, first_valid, last_hs, done_cyc;
        bit seen_done, prev_stall;
        logic [VW-1:0] prev_data;
        cyc = 0; hs = 0; rds = 0;
        first_valid = -1; last_hs = -1; done_cyc = -1;
        seen_done = 0; prev_stall = 0; prev_data = '0;
        mode = md;
        start = 1'b1;
        out_ready = 1'b1;
        while (!seen_done && cyc < 300) begin
            tick();
            cyc++;
            start = (cyc == again);
            mode = 1'($urandom);
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 6 == 0) || (cyc % 6 == 3) ||
                               (cyc % 6 == 5);
                default: out_ready = ($urandom % 3) != 0;
            endcase
            #1;
            if (mem_rd_en) begin
                if (timing && rds == 0) chk("first_rd_cyc", cyc, 1);
                chk("rd_addr", mem_addr, rds);
                rds++;
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", out_data, prev_data);
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                if (hs < DEPTH) begin
                    chk("data", out_data, ref_vec(hs / LW, hs % LW, md));
                    cap[hs] = out_data;
                end else begin
                    chk("hs_count", hs, DEPTH - 1);
                end
                hs++;
                last_hs = cyc;
            end
            if (done) begin
                seen_done = 1;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end else begin
                chk("busy", busy, 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
        chk("done_seen", seen_done, 1);
        chk("hs_total", hs, DEPTH);
        chk("rd_total", rds, DEPTH);
        if (timing) begin
            chk("first_valid_cyc", first_valid, 4);
            chk("last_hs_cyc", last_hs, NL * (LW + 3));
            chk("done_cyc", done_cyc, NL * (LW + 3) + 1);
        end
        tick();
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rd", mem_rd_en, 0);
    endtask

    int exp_med [4];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_idle_outs("reset");

        fill_random();
        mem[0][0] = 8'd0;
        mem[0][1] = 8'd40;
        mem[0][2] = 8'd80;
        mem[0][3] = 8'd120;
        run_frame(1'b0, 0, 1'b1, 6);
        chk("mean_x0", cap[0] & 16'h00ff, 10);
        chk("mean_x1", cap[1] & 16'h00ff, 40);
        chk("mean_x2", cap[2] & 16'h00ff, 80);
        chk("mean_x3", cap[3] & 16'h00ff, 110);

        fill_random();
        mem[0][0] = 8'd10;
        mem[0][1] = 8'd200;
        mem[0][2] = 8'd30;
        mem[0][3] = 8'd30;
        exp_med[0] = MED_EN ? 10 : 57;
        exp_med[1] = MED_EN ? 30 : 110;
        exp_med[2] = MED_EN ? 30 : 72;
        exp_med[3] = 30;
        run_frame(1'b1, 0, 1'b0, -1);
        for (int i = 0; i < 4; i++)
            chk("median_x", cap[i] & 16'h00ff, exp_med[i]);

        for (int k = 0; k < NB; k++)
            for (int a = 0; a < DEPTH; a++)
                mem[k][a] = 8'hff;
        run_frame(1'b0, 0, 1'b0, -1);
        for (int i = 0; i < DEPTH; i++)
            chk("saturate", cap[i], 16'hffff);

        fill_random();
        run_frame(1'b0, 1, 1'b0, -1);
        fill_random();
        run_frame(1'b1, 1, 1'b0, -1);

        fill_random();
        mode = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk_idle_outs("midrst1");
        tick();
        rst = 1'b0;
        #1;
        chk_idle_outs("midrst2");
        tick();
        chk("post_rst_busy", busy, 0);
        run_frame(1'b0, 2, 1'b0, -1);

        repeat (4) begin
            fill_random();
            run_frame(1'($urandom), 2, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
